data_memory_responder: RTL and testbench
========================================

Name: data_memory_responder

Overview:
- Memory-side responder for the 256-bit line-refill/write-back interface driven by the data-cache controller.
- Accepts one line request at a time (read or write), waits a programmable fixed latency, then commits the write or returns the line with a one-cycle acknowledge.
- Backs a line-addressed storage array; used as the data memory in the CPU top level and in cache benches.

Parameters:
- LINE_W, 256, line width in bits.
- ADDR_W, 32, byte-address width.
- IDX_W, 9, line-index width; depth = 2**IDX_W lines.
- LATENCY, 10, cycles from request acceptance to ack (legal range 1..255).

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  reset, synchronous, active-low.
- enable_i  in  1  request valid from the cache.
- write_i  in  1  1 = line write, 0 = line read; sampled with enable_i.
- addr_i  in  ADDR_W  byte address; line index = addr_i[5+IDX_W-1:5]; bits [4:0] and the bits above the index are ignored.
- data_i  in  LINE_W  write line; sampled at acceptance.
- ack_o  out  1  one-cycle completion pulse.
- data_o  out  LINE_W  read line; valid in the ack cycle and held until the next read completes.

Behaviour:
- Reset: if rst_i is low at a clock edge, then
  - state goes to IDLE, the counter goes to 0, ack_o goes to 0 and data_o goes to 0;
  - the storage array is not cleared;
  - an in-flight transaction is dropped and no write is committed.
- States:
  - IDLE: if enable_i = 1, capture write_i, the index and data_i; load counter = LATENCY-1; go to BUSY. Otherwise stay in IDLE.
  - BUSY: while counter != 0, decrement it. When counter == 0, assert ack_o for this cycle and perform the operation:
    - write: mem[idx] <= captured data.
    - read: data_o <= mem[idx].
    - Next state: IDLE after a write, DRAIN after a read.
  - DRAIN: stay until enable_i = 0, then go to IDLE. Requests are not accepted in DRAIN.
- Latency: request first seen in IDLE at cycle T -> ack_o = 1 in cycle T+LATENCY. For LATENCY = 1, BUSY lasts exactly one cycle and that cycle carries the ack.
- Read data timing: data_o is registered, so it shows the new line from the cycle after the ack edge.
  - Required rule: the captured read data appears on data_o in the same cycle ack_o is high.
  - Therefore the read of mem[idx] is registered on the edge that enters the ack cycle, i.e. it is done when counter transitions 1->0, or at acceptance when LATENCY = 1.
- Turnaround rules:
  - After a write ack, a request held high in the next cycle is a new transaction and is accepted immediately. This covers write-back followed by refill with enable_i never dropping.
  - After a read ack, the cache holds enable_i high for at least one more cycle; DRAIN guarantees this is not taken as a repeat read.
- Inputs changing during BUSY are ignored, because all request fields are captured at acceptance.
- enable_i dropping during BUSY does not abort: the ack is still issued and a write is still committed.
- ack_o is never high in two consecutive cycles.
- At most one transaction is in flight.
- Address aliasing: upper address bits are ignored, so addresses differing only above the index alias to the same line.

Test Plan:
- Reset with enable_i = 0 -> ack_o = 0 and data_o = 0 for 20 cycles; state stays IDLE.
- Write 0xA5A5...A5 to addr 0x0000_0040 at cycle T (LATENCY = 10) -> ack_o high only in cycle T+10. Then read the same addr -> ack_o 10 cycles after acceptance, with data_o = 0xA5A5...A5 in the ack cycle.
- Write-back then refill: write to 0x0000_0400 with enable_i held high, then write_i -> 0 and addr 0x0000_0800 in the cycle after the ack -> the second ack comes exactly LATENCY cycles later and returns the line stored at index 64.
- Read with enable_i held high for 1 cycle after the ack, then low -> exactly one ack; no second transaction starts; the next request is accepted only after enable_i = 0 has been seen.
- Reset pulse in cycle T+5 of a write to 0x20 -> no ack; a later read of 0x20 returns the pre-write contents.
- LATENCY = 1 build: read at T -> ack_o at T+1 with correct data_o. Addresses 0x0000_0020 and 0x0000_4020 alias to index 1, so a write to one is returned by a read of the other.

Source files
------------

// File: rtl/data_memory_responder_if.sv
// Line-refill/write-back bus between the data-cache controller (master)
// and the memory responder (slave).
interface data_memory_responder_if #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) ();

  logic              enable;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [LINE_W-1:0] wdata;
  logic              ack;
  logic [LINE_W-1:0] rdata;

  modport master (
    output enable, write, addr, wdata,
    input  ack, rdata
  );

  modport slave (
    input  enable, write, addr, wdata,
    output ack, rdata
  );

endinterface

// File: rtl/data_memory_responder.sv
// Line-addressed data memory: accepts one line read/write at a time, answers
// after a fixed latency with a one-cycle ack; read data is valid in the ack cycle.
module data_memory_responder #(
  parameter int LINE_W  = 256,
  parameter int ADDR_W  = 32,
  parameter int IDX_W   = 9,
  parameter int LATENCY = 10
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  data_memory_responder_if.slave  bus
);

  localparam int         DEPTH    = 2 ** IDX_W;
  localparam int         OFF_W    = 5;
  localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);
  localparam bit         LAT_ONE  = (LATENCY == 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DRAIN
  } state_t;

  state_t            state, state_nxt;
  logic [7:0]        cnt, cnt_nxt;
  logic              accept;
  logic              done;
  logic              rd_load;
  logic              mem_we;

  logic              cap_write;
  logic [IDX_W-1:0]  cap_idx;
  logic [LINE_W-1:0] cap_data;

  logic [IDX_W-1:0]  req_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic              addr_unused;

  logic [LINE_W-1:0] mem [DEPTH];

  // Offset bits and everything above the index are don't-care: lines alias.
  assign req_idx     = bus.addr[OFF_W +: IDX_W];
  assign addr_unused = ^{bus.addr[ADDR_W-1:OFF_W+IDX_W], bus.addr[OFF_W-1:0]};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.enable) begin
          accept    = 1'b1;
          cnt_nxt   = CNT_LOAD;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (cnt == 8'd0) begin
          done      = 1'b1;
          state_nxt = cap_write ? IDLE : DRAIN;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      DRAIN: begin
        // The cache keeps enable high past a read ack; wait for it to drop.
        if (!bus.enable) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.ack = done;

  // A reset landing on the ack edge drops the transaction, so gate the commit.
  assign mem_we = done && cap_write && rst_i;

  // Load the read register on the edge that enters the ack cycle, so the line
  // is on rdata while ack is high.
  assign rd_load = (accept && !bus.write && LAT_ONE) ||
                   (state == BUSY && cnt == 8'd1 && !cap_write);
  assign rd_idx  = (state == IDLE) ? req_idx : cap_idx;

  always_ff @(posedge clk_i) begin
    if (accept) begin
      cap_write <= bus.write;
      cap_idx   <= req_idx;
      cap_data  <= bus.wdata;
    end
  end

  // NOTE: the storage array and capture registers carry no reset; their
  // contents are only consumed after being written.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem[cap_idx] <= cap_data;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      bus.rdata <= '0;
    end else if (rd_load) begin
      bus.rdata <= mem[rd_idx];
    end
  end

  ack_single_cycle: assert property (@(posedge clk_i) disable iff (!rst_i)
    bus.ack |=> !bus.ack);

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for two responder builds (LATENCY 10 and 1); expected acks are
// queued at issue time and matched by a monitor on each ack.
module tb_data_memory_responder;

  localparam int LINE_W = 256;

  typedef struct {
    int                cyc;
    bit                rd;
    logic [LINE_W-1:0] data;
  } exp_t;

  logic              clk;
  logic [1:0]        rst;
  logic [1:0]        en;
  logic [1:0]        wr;
  logic [31:0]       ad [2];
  logic [LINE_W-1:0] wd [2];
  int                cyc;
  int                n_cmp;
  int                n_bad;
  exp_t              sb0 [$];
  exp_t              sb1 [$];

  data_memory_responder_if bus0 ();
  data_memory_responder_if bus1 ();

  assign bus0.enable = en[0];
  assign bus0.write  = wr[0];
  assign bus0.addr   = ad[0];
  assign bus0.wdata  = wd[0];
  assign bus1.enable = en[1];
  assign bus1.write  = wr[1];
  assign bus1.addr   = ad[1];
  assign bus1.wdata  = wd[1];

  data_memory_responder #(.LATENCY(10)) dut0 (
    .clk_i (clk),
    .rst_i (rst[0]),
    .bus   (bus0)
  );

  data_memory_responder #(.LATENCY(1)) dut1 (
    .clk_i (clk),
    .rst_i (rst[1]),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat(int d);
    return (d == 0) ? 10 : 1;
  endfunction

  task automatic check(string name, logic [LINE_W-1:0] act, logic [LINE_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive a request in the current cycle; optionally queue its expected ack.
  task automatic issue(int d, bit w, logic [31:0] a, logic [LINE_W-1:0] wdat,
                       logic [LINE_W-1:0] exp_rd, bit push);
    exp_t e;
    en[d] = 1'b1;
    wr[d] = w;
    ad[d] = a;
    wd[d] = wdat;
    e.cyc  = cyc + lat(d);
    e.rd   = !w;
    e.data = exp_rd;
    if (push) begin
      if (d == 0) sb0.push_back(e);
      else        sb1.push_back(e);
    end
  endtask

  // Write held for one cycle, then idle past the ack.
  task automatic wr_tail(int d);
    step(1);
    en[d] = 1'b0;
    step(lat(d) + 1);
  endtask

  // Read: enable stays high through the ack and `hold` more cycles, then drops.
  task automatic rd_tail(int d, int hold);
    step(lat(d) + hold + 1);
    en[d] = 1'b0;
    step(1);
  endtask

  task automatic mon(int d, logic [LINE_W-1:0] rdat);
    exp_t e;
    if ((d == 0 && sb0.size() == 0) || (d == 1 && sb1.size() == 0)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_ack dut%0d: ack at cycle %0d, none pending", d, cyc);
      return;
    end
    e = (d == 0) ? sb0.pop_front() : sb1.pop_front();
    check($sformatf("ack_cycle_dut%0d", d), LINE_W'(cyc), LINE_W'(e.cyc));
    if (e.rd) check($sformatf("read_data_dut%0d", d), rdat, e.data);
  endtask

  always @(negedge clk) begin
    if (bus0.ack === 1'b1) mon(0, bus0.rdata);
    if (bus1.ack === 1'b1) mon(1, bus1.rdata);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LINE_W-1:0] pa5, p64, p3c, p1, p2, p3, p4;
    pa5 = {32{8'hA5}};
    p64 = {8{32'h0BAD_F00D}};
    p3c = {32{8'h3C}};
    p1  = {8{32'h1234_5678}};
    p2  = {8{32'hDEAD_BEEF}};
    p3  = {16{16'hC0DE}};
    p4  = {4{64'h0123_4567_89AB_CDEF}};
    n_cmp = 0;
    n_bad = 0;
    rst = 2'b00;
    en  = 2'b00;
    wr  = 2'b00;
    for (int i = 0; i < 2; i++) begin
      ad[i] = '0;
      wd[i] = '0;
    end

    // Reset, then idle with enable low: no ack, data zero.
    step(3);
    rst = 2'b11;
    for (int i = 0; i < 20; i++) begin
      step(1);
      check("idle_ack0", LINE_W'(bus0.ack), '0);
      check("idle_data0", bus0.rdata, '0);
      check("idle_ack1", LINE_W'(bus1.ack), '0);
      check("idle_data1", bus1.rdata, '0);
    end

    // Write A5 to 0x40; enable drops and fields change while busy.
    issue(0, 1'b1, 32'h0000_0040, pa5, '0, 1'b1);
    step(1);
    en[0] = 1'b0;
    wr[0] = 1'b0;
    ad[0] = 32'h0000_0800;
    wd[0] = '0;
    step(lat(0) + 1);
    check("rdata_unchanged_by_write", bus0.rdata, '0);

    // Read it back.
    issue(0, 1'b0, 32'h0000_0040, '0, pa5, 1'b1);
    rd_tail(0, 1);

    // Seed index 64, then write-back 0x400 followed by refill of 0x800
    // with enable never dropping.
    issue(0, 1'b1, 32'h0000_0800, p64, '0, 1'b1);
    wr_tail(0);
    check("rdata_held", bus0.rdata, pa5);
    issue(0, 1'b1, 32'h0000_0400, p3c, '0, 1'b1);
    step(lat(0) + 1);
    issue(0, 1'b0, 32'h0000_0800, '0, p64, 1'b1);
    rd_tail(0, 1);

    // Read with enable held 3 cycles past the ack, then a fresh request
    // right after enable has been seen low.
    issue(0, 1'b0, 32'h0000_0400, '0, p3c, 1'b1);
    rd_tail(0, 3);
    issue(0, 1'b0, 32'h0000_0040, '0, pa5, 1'b1);
    rd_tail(0, 1);
    step(lat(0) + 2);

    // Reset in cycle T+5 of a write to 0x20: no ack, no commit.
    issue(0, 1'b1, 32'h0000_0020, p1, '0, 1'b1);
    wr_tail(0);
    issue(0, 1'b1, 32'h0000_0020, p2, '0, 1'b0);
    step(1);
    en[0] = 1'b0;
    step(4);
    rst[0] = 1'b0;
    step(1);
    rst[0] = 1'b1;
    check("reset_clears_data", bus0.rdata, '0);
    check("reset_clears_ack", LINE_W'(bus0.ack), '0);
    step(lat(0) + 2);
    issue(0, 1'b0, 32'h0000_0020, '0, p1, 1'b1);
    rd_tail(0, 1);

    // LATENCY 1 build: aliasing of 0x20 and 0x4020, back-to-back write/read.
    issue(1, 1'b1, 32'h0000_0020, p3, '0, 1'b1);
    wr_tail(1);
    issue(1, 1'b0, 32'h0000_4020, '0, p3, 1'b1);
    rd_tail(1, 1);
    issue(1, 1'b1, 32'h0000_4020, p4, '0, 1'b1);
    step(lat(1) + 1);
    issue(1, 1'b0, 32'h0000_0020, '0, p4, 1'b1);
    rd_tail(1, 1);

    step(4);
    check("all_acks_seen_dut0", LINE_W'(sb0.size()), '0);
    check("all_acks_seen_dut1", LINE_W'(sb1.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
